prog_sequencer: RTL and testbench
=================================

PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameter PC_W, default 10: width of the program-counter init address.
REQ-002 Parameter CNT_W, default 16: width of the per-program cycle counter.
REQ-003 Parameter TIMEOUT, default 50000: RUN-cycle limit before forced completion.
REQ-004 Port Clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 Port Reset  in  1  reset; asynchronous and active-low.
REQ-006 Port Start  in  1  launch request from the bench or host; level signal.
REQ-007 Port CoreDone  in  1  halt indication from the core; meaningful only in RUN.
REQ-008 Port Ack  out  1  done flag to the bench; registered.
REQ-009 Port CoreRun  out  1  core enable; PC and register/memory writes advance only while it is 1.
REQ-010 Port PcLoad  out  1  one-cycle strobe that loads PcInit into the program counter.
REQ-011 Port PcInit  out  PC_W  start address of the selected program.
REQ-012 Port ProgSel  out  2  selected program: 0=P1, 1=P2, 2=P3; the value 3 never occurs.
REQ-013 Port CycleCnt  out  CNT_W  RUN cycles of the current or last program.
REQ-014 Port Timeout  out  1  last program ended by watchdog, not by CoreDone.

Function
REQ-015 States SHALL be IDLE, ARMED, LOAD, RUN and DONE; the state is registered.
REQ-016 IDLE: Start=1 -> ARMED; otherwise stay in IDLE.
REQ-017 ARMED: stay while Start=1; Start=0 -> LOAD, so the launch occurs on Start deassertion.
REQ-018 LOAD: PcLoad=1 for exactly this one cycle; CycleCnt cleared to 0; Timeout cleared to 0; -> RUN unconditionally.
REQ-019 PcInit SHALL be combinational from ProgSel: P1_BASE, P2_BASE or P3_BASE.
REQ-020 RUN: CoreRun=1; CycleCnt increments by 1 each cycle and saturates at all-ones.
REQ-021 RUN: CoreDone=1 -> DONE, with Timeout held at 0.
REQ-022 RUN: when CycleCnt = TIMEOUT-1 and CoreDone=0 -> DONE, and Timeout set to 1.
REQ-023 RUN: if CoreDone=1 in the same cycle as the timeout condition, CoreDone wins and Timeout stays 0.
REQ-024 RUN: Start SHALL be ignored.
REQ-025 DONE: Ack=1; CoreRun=0; CycleCnt and Timeout frozen, so they are readable by the bench.
REQ-026 DONE: Start=1 -> ARMED; Ack falls on that same edge; ProgSel advances 0->1->2->0 (wrap) on that same edge.
REQ-027 CoreDone outside RUN SHALL be ignored.
REQ-028 Ack, CoreRun and PcLoad are mutually exclusive in every cycle.
REQ-029 Minimum Start-deassert-to-CoreRun latency: 1 cycle (LOAD), then CoreRun=1 in the next cycle.

Reset
REQ-030 Reset=0 forces the following immediately, regardless of state, including mid-RUN: state=IDLE, Ack=0, CoreRun=0, PcLoad=0, ProgSel=0, CycleCnt=0, Timeout=0.
REQ-031 After Reset rises, no transition occurs before the first rising Clk edge that samples Start=1.

Structure
REQ-032 Package prog_seq_pkg SHALL hold the state enum type and the constants P1_BASE=10'd0, P2_BASE=10'd200, P3_BASE=10'd400.
REQ-033 The saturating cycle counter SHALL be one sub-module, cycle_ctr (ports: clr, en, count).
REQ-034 All other logic lives in prog_sequencer; there are no latches and no other clocks.

Verification
REQ-035 Reset, Start=1 for 1 cycle, CoreDone after 20 RUN cycles -> PcLoad pulse with PcInit=0; Ack=1; CycleCnt=20; Timeout=0; ProgSel=0.
REQ-036 Three Start/CoreDone rounds -> PcInit = 0, then 200, then 400; a fourth Start wraps ProgSel to 0 with PcInit=0.
REQ-037 TIMEOUT=8, CoreDone never asserted -> DONE after 8 RUN cycles; Ack=1; Timeout=1; CycleCnt=7.
REQ-038 TIMEOUT=8, CoreDone asserted in the 8th RUN cycle -> Timeout=0; Ack=1.
REQ-039 Start pulsed during RUN -> no state change and no ProgSel change; Ack asserted only on CoreDone.
REQ-040 Reset driven low in the middle of RUN for P2 -> outputs go to reset values asynchronously; the next Start runs P1 (PcInit=0).

Source files
------------

// File: rtl/prog_seq_pkg.sv
// Shared definitions for the program sequencer.
//   prog_state_e : sequencer FSM state encoding
//   P1_BASE..P3_BASE : start addresses of the three resident programs
//   prog_base()  : maps a program select code to its start address
package prog_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } prog_state_e;

  localparam logic [9:0] P1_BASE = 10'd0;
  localparam logic [9:0] P2_BASE = 10'd200;
  localparam logic [9:0] P3_BASE = 10'd400;

  // Select code 3 is never produced; it falls back to P1 so the decode is total.
  function automatic logic [9:0] prog_base(input logic [1:0] sel);
    logic [9:0] base;
    case (sel)
      2'd1:    base = P2_BASE;
      2'd2:    base = P3_BASE;
      default: base = P1_BASE;
    endcase
    return base;
  endfunction

endpackage

// File: rtl/cycle_ctr.sv
// Saturating up-counter measuring RUN cycles of a program.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : count one cycle
//   count      : current count, sticks at all-ones
module cycle_ctr #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: launches one of three resident programs on a core,
// watches it run, and reports completion to the host.
// Ports:
//   Clk, Reset    : clock, asynchronous active-low reset
//   Start         : host launch request (level)
//   CoreDone      : core halt indication, only looked at in RUN
//   Ack           : registered done flag, high while in DONE
//   CoreRun       : core enable, high while in RUN
//   PcLoad        : one-cycle strobe in LOAD, loads PcInit into the core PC
//   PcInit        : start address of the selected program
//   ProgSel       : selected program (0=P1, 1=P2, 2=P3)
//   CycleCnt      : RUN cycles of the current/last program
//   Timeout       : last program was ended by the watchdog
//   state_dbg     : current FSM state, for observation only
//
// Host handshake: the host raises Start to arm the sequencer and the program
// launches when Start falls. Ack then stays high in DONE until the host raises
// Start again; that same edge drops Ack, selects the next program and re-arms.
// Start is ignored while a program is loading or running.
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int PC_W    = 10,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             CoreDone,
  output logic             Ack,
  output logic             CoreRun,
  output logic             PcLoad,
  output logic [PC_W-1:0]  PcInit,
  output logic [1:0]       ProgSel,
  output logic [CNT_W-1:0] CycleCnt,
  output logic             Timeout,
  output prog_state_e      state_dbg
);

  prog_state_e state_q, state_d;
  logic        cnt_clr;
  logic        cnt_en;
  logic        timeout_hit;
  logic        ack_q, run_q, load_q, timeout_q;
  logic [1:0]  sel_q;

  // Watchdog fires in the RUN cycle where the count reaches TIMEOUT-1.
  assign timeout_hit = (CycleCnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ST_IDLE:  if (Start) state_d = ST_ARMED;
      ST_ARMED: if (!Start) state_d = ST_LOAD;
      ST_LOAD: begin
        cnt_clr = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // A watchdog exit freezes the count at TIMEOUT-1; a CoreDone exit
        // (which wins a tie) still counts its final cycle.
        cnt_en = !(timeout_hit && !CoreDone);
        if (CoreDone || timeout_hit) state_d = ST_DONE;
      end
      ST_DONE:  if (Start) state_d = ST_ARMED;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Status outputs are flopped from the next state so they line up exactly
  // with the state register and never glitch.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_IDLE;
      ack_q     <= 1'b0;
      run_q     <= 1'b0;
      load_q    <= 1'b0;
      timeout_q <= 1'b0;
      sel_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      ack_q   <= (state_d == ST_DONE);
      run_q   <= (state_d == ST_RUN);
      load_q  <= (state_d == ST_LOAD);

      if (state_q == ST_LOAD) begin
        timeout_q <= 1'b0;
      end else if ((state_q == ST_RUN) && timeout_hit && !CoreDone) begin
        timeout_q <= 1'b1;
      end

      if ((state_q == ST_DONE) && Start) begin
        sel_q <= (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
      end
    end
  end

  cycle_ctr #(.W(CNT_W)) u_cycle_ctr (
    .clk   (Clk),
    .rst_n (Reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (CycleCnt)
  );

  assign Ack       = ack_q;
  assign CoreRun   = run_q;
  assign PcLoad    = load_q;
  assign Timeout   = timeout_q;
  assign ProgSel   = sel_q;
  assign PcInit    = PC_W'(prog_base(sel_q));
  assign state_dbg = state_q;

endmodule

// File: tb/tb_prog_sequencer.sv
module tb_prog_sequencer;
  import prog_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // DUT A: default parameters
  logic        start_a = 1'b0, done_a = 1'b0;
  logic        ack_a, run_a, load_a, tmo_a;
  logic [9:0]  pcinit_a;
  logic [1:0]  sel_a;
  logic [15:0] cnt_a;
  prog_state_e st_a;

  // DUT B: short watchdog
  logic        start_b = 1'b0, done_b = 1'b0;
  logic        ack_b, run_b, load_b, tmo_b;
  logic [9:0]  pcinit_b;
  logic [1:0]  sel_b;
  logic [15:0] cnt_b;
  prog_state_e st_b;

  prog_sequencer u_dut_a (
    .Clk(clk), .Reset(rst_n), .Start(start_a), .CoreDone(done_a),
    .Ack(ack_a), .CoreRun(run_a), .PcLoad(load_a), .PcInit(pcinit_a),
    .ProgSel(sel_a), .CycleCnt(cnt_a), .Timeout(tmo_a), .state_dbg(st_a)
  );

  prog_sequencer #(.TIMEOUT(8)) u_dut_b (
    .Clk(clk), .Reset(rst_n), .Start(start_b), .CoreDone(done_b),
    .Ack(ack_b), .CoreRun(run_b), .PcLoad(load_b), .PcInit(pcinit_b),
    .ProgSel(sel_b), .CycleCnt(cnt_b), .Timeout(tmo_b), .state_dbg(st_b)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];
  logic chk_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic report();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
  endtask

  // Ack, CoreRun and PcLoad must never overlap.
  always @(negedge clk) begin
    if (chk_en) begin
      check("excl_a", 32'((ack_a & run_a) | (ack_a & load_a) | (run_a & load_a)), 32'd0);
      check("excl_b", 32'((ack_b & run_b) | (ack_b & load_b) | (run_b & load_b)), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch program on DUT A and end it with CoreDone in RUN cycle n.
  task automatic run_prog(input int n, input logic [9:0] exp_init, input logic [1:0] exp_sel);
    logic [15:0] exp_cnt;
    exp_q.push_back(16'(n));
    start_a = 1'b1;
    step();
    check("armed_state", 32'(st_a), 32'(ST_ARMED));
    check("armed_ack", 32'(ack_a), 32'd0);
    check("armed_sel", 32'(sel_a), 32'(exp_sel));
    start_a = 1'b0;
    step();
    check("load_pcload", 32'(load_a), 32'd1);
    check("load_pcinit", 32'(pcinit_a), 32'(exp_init));
    check("load_corerun", 32'(run_a), 32'd0);
    step();
    check("run1_corerun", 32'(run_a), 32'd1);
    check("run1_pcload", 32'(load_a), 32'd0);
    check("run1_cnt", 32'(cnt_a), 32'd0);
    repeat (n - 1) step();
    check("runN_cnt", 32'(cnt_a), 32'(n - 1));
    done_a = 1'b1;
    step();
    done_a = 1'b0;
    exp_cnt = exp_q.pop_front();
    check("done_ack", 32'(ack_a), 32'd1);
    check("done_corerun", 32'(run_a), 32'd0);
    check("done_cnt", 32'(cnt_a), 32'(exp_cnt));
    check("done_timeout", 32'(tmo_a), 32'd0);
    check("done_sel", 32'(sel_a), 32'(exp_sel));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #3 rst_n = 1'b0;
    #1;
    check("rst_ack", 32'(ack_a), 32'd0);
    check("rst_run", 32'(run_a), 32'd0);
    check("rst_load", 32'(load_a), 32'd0);
    check("rst_sel", 32'(sel_a), 32'd0);
    check("rst_cnt", 32'(cnt_a), 32'd0);
    check("rst_tmo", 32'(tmo_a), 32'd0);
    check("rst_state", 32'(st_a), 32'(ST_IDLE));
    @(posedge clk);
    #3 rst_n = 1'b1;
    chk_en = 1'b1;
    step();
    step();
    check("idle_hold", 32'(st_a), 32'(ST_IDLE));
    // CoreDone outside RUN is ignored
    done_a = 1'b1;
    step();
    done_a = 1'b0;
    check("idle_coredone", 32'(st_a), 32'(ST_IDLE));
    check("idle_ack", 32'(ack_a), 32'd0);

    // ---- watchdog on DUT B (TIMEOUT=8) ----
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    step();
    step();
    repeat (7) step();
    check("b_run8_corerun", 32'(run_b), 32'd1);
    check("b_run8_cnt", 32'(cnt_b), 32'd7);
    step();
    check("b_wd_ack", 32'(ack_b), 32'd1);
    check("b_wd_timeout", 32'(tmo_b), 32'd1);
    check("b_wd_cnt", 32'(cnt_b), 32'd7);
    check("b_wd_corerun", 32'(run_b), 32'd0);
    step();
    check("b_frozen_cnt", 32'(cnt_b), 32'd7);
    check("b_frozen_tmo", 32'(tmo_b), 32'd1);
    // CoreDone in the 8th RUN cycle wins over the watchdog
    start_b = 1'b1;
    step();
    check("b_armed_sel", 32'(sel_b), 32'd1);
    start_b = 1'b0;
    step();
    step();
    check("b_run1_tmo", 32'(tmo_b), 32'd0);
    repeat (7) step();
    check("b_tie_cnt", 32'(cnt_b), 32'd7);
    done_b = 1'b1;
    step();
    done_b = 1'b0;
    check("b_tie_ack", 32'(ack_b), 32'd1);
    check("b_tie_timeout", 32'(tmo_b), 32'd0);
    check("b_tie_cnt_done", 32'(cnt_b), 32'd8);

    // ---- basic launch and program rotation on DUT A ----
    run_prog(20, 10'd0, 2'd0);
    // CoreDone in DONE is ignored; values stay frozen
    done_a = 1'b1;
    step();
    done_a = 1'b0;
    check("done_hold_ack", 32'(ack_a), 32'd1);
    check("done_hold_cnt", 32'(cnt_a), 32'd20);
    run_prog(5, 10'd200, 2'd1);
    run_prog(7, 10'd400, 2'd2);
    run_prog(3, 10'd0, 2'd0);

    // ---- Start pulsed during RUN is ignored ----
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step();
    check("sp_pcinit", 32'(pcinit_a), 32'd200);
    step();
    start_a = 1'b1;
    step();
    check("sp_state", 32'(st_a), 32'(ST_RUN));
    check("sp_sel", 32'(sel_a), 32'd1);
    check("sp_ack", 32'(ack_a), 32'd0);
    step();
    start_a = 1'b0;
    step();
    check("sp_state2", 32'(st_a), 32'(ST_RUN));
    check("sp_cnt", 32'(cnt_a), 32'd3);
    done_a = 1'b1;
    step();
    done_a = 1'b0;
    check("sp_done_ack", 32'(ack_a), 32'd1);
    check("sp_done_cnt", 32'(cnt_a), 32'd4);
    check("sp_done_sel", 32'(sel_a), 32'd1);

    run_prog(4, 10'd400, 2'd2);
    run_prog(4, 10'd0, 2'd0);

    // ---- asynchronous reset in the middle of P2 ----
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step();
    step();
    step();
    step();
    check("mid_run", 32'(run_a), 32'd1);
    check("mid_sel", 32'(sel_a), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_run", 32'(run_a), 32'd0);
    check("ar_ack", 32'(ack_a), 32'd0);
    check("ar_load", 32'(load_a), 32'd0);
    check("ar_sel", 32'(sel_a), 32'd0);
    check("ar_cnt", 32'(cnt_a), 32'd0);
    check("ar_tmo", 32'(tmo_a), 32'd0);
    check("ar_state", 32'(st_a), 32'(ST_IDLE));
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    check("post_rst_idle", 32'(st_a), 32'(ST_IDLE));
    run_prog(6, 10'd0, 2'd0);

    chk_en = 1'b0;
    report();
    $finish;
  end

  // Bound on total run time.
  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    report();
    $finish;
  end

endmodule
